// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: framed serial transmitter for the "1-then-0" pattern line.
//
// Accepts a DATA_W-bit word through a valid/ready handshake and sends one frame
// on Out1, one bit per CLK:
//   preamble 1,0 | payload MSB-first | optional even-parity bit | stop bit 1
// A word accepted during the stop cycle starts the next frame with no idle gap.
//
// Build option:
//   SERIAL_PATTERN_TX_PARITY_EN  defined   -> PAR state between DATA and STOP
//                                undefined -> DATA goes straight to STOP
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   asynchronous reset, active low
//   In_Valid  in   a word is offered on In_Data
//   In_Data   in   payload word, sampled on the acceptance edge only
//   In_Ready  out  word can be accepted this cycle (IDLE or STOP)
//   Out1      out  registered serial line, idle level 0
//   Busy      out  a frame is in progress
//   Done      out  high during the stop-bit cycle
module serial_pattern_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Out1,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre1 = 3'd1,
    StPre0 = 3'd2,
    StData = 3'd3,
    StPar  = 3'd4,
    StStop = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              accept;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign In_Ready = (state_q == StIdle) || (state_q == StStop);
  assign accept   = In_Valid && In_Ready;
  assign Busy     = (state_q != StIdle);
  assign Done     = (state_q == StStop);
  assign Out1     = out_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      StIdle: state_d = StIdle;
      StPre1: state_d = StPre0;
      StPre0: state_d = StData;
      StData: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_d = StPar;
`else
          state_d = StStop;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      StPar:  state_d = StStop;
`endif
      StStop: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Acceptance is only possible in IDLE or STOP and always starts a new frame.
    if (accept) begin
      shift_d = In_Data;
      cnt_d   = CntW'(DATA_W - 1);
      state_d = StPre1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_d   = ^In_Data;
`endif
    end
  end

  // Out1 is registered, so its next value is decoded from the next state.
  always_comb begin
    out_d = 1'b0;
    case (state_d)
      StPre1: out_d = 1'b1;
      StPre0: out_d = 1'b0;
      StData: out_d = shift_d[DATA_W-1];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      StPar:  out_d = par_d;
`endif
      StStop: out_d = 1'b1;
      default: out_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: DATA_W=8 instance checked cycle by cycle
// against a frame-queue reference model, plus a DATA_W=1 instance checked
// with a directed sequence.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, out1, busy, done;

  logic       in_valid1 = 1'b0;
  logic [0:0] in_data1 = '0;
  logic       in_ready1, out1_1, busy1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.DATA_W(8)) u_dut (
    .CLK      (clk),
    .RST      (rst),
    .In_Valid (in_valid),
    .In_Data  (in_data),
    .In_Ready (in_ready),
    .Out1     (out1),
    .Busy     (busy),
    .Done     (done)
  );

  serial_pattern_tx #(.DATA_W(1)) u_dut1 (
    .CLK      (clk),
    .RST      (rst),
    .In_Valid (in_valid1),
    .In_Data  (in_data1),
    .In_Ready (in_ready1),
    .Out1     (out1_1),
    .Busy     (busy1),
    .Done     (done1)
  );

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int FrameLen = 8 + 3 + (ParEn ? 1 : 0);

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
  } exp_t;

  localparam exp_t IdleExp = '{out: 1'b0, busy: 1'b0, done: 1'b0};

  // Expected line contents of cycle i of a frame carrying word w.
  function automatic exp_t frame_elem(input logic [7:0] w, input int i);
    exp_t e;
    e.busy = 1'b1;
    e.done = (i == FrameLen - 1);
    if (i == 0)                   e.out = 1'b1;
    else if (i == 1)              e.out = 1'b0;
    else if (i < 10)              e.out = w[7 - (i - 2)];
    else if (ParEn && (i == 10))  e.out = ^w;
    else                          e.out = 1'b1;
    return e;
  endfunction

  exp_t exp_q[$];
  exp_t cur = IdleExp;

  // Reference model: a word is taken whenever the line is idle or on its stop
  // bit; its whole frame is then queued and one entry is consumed per cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      cur <= IdleExp;
    end else begin
      if (in_valid && (!cur.busy || cur.done)) begin
        for (int i = 0; i < FrameLen; i++) exp_q.push_back(frame_elem(in_data, i));
      end
      if (exp_q.size() > 0) begin
        cur <= exp_q[0];
        void'(exp_q.pop_front());
      end else begin
        cur <= IdleExp;
      end
    end
  end

  // Monitor: compares every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] got, expv;
    got  = {out1, busy, done, in_ready};
    expv = {cur.out, cur.busy, cur.done, (!cur.busy || cur.done)};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL cycle t=%0t {out1,busy,done,ready} got %b expected %b", $time, got, expv);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  // Offer w and return right after the edge that accepts it; In_Valid stays high.
  task automatic send8(input logic [7:0] w);
    int   n;
    logic rdy;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        check("send8_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drop8();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  initial begin
    logic [12:0] seq;
    logic [12:0] seq_done;
    logic [5:0]  seq1;
    logic [5:0]  seq1_done;
    int          r;

    // Reset and idle line.
    #1 check("reset_out1", 32'(out1), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd1);

    // Directed 0xA5 frame followed by an idle bit.
    send8(8'hA5);
    seq      = ParEn ? 13'b1010100101010 : 13'b0101010010110;
    seq_done = ParEn ? 13'b0000000000010 : 13'b0000000000010;
    for (int i = 0; i < FrameLen + 1; i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
      end
      check($sformatf("a5_bit%0d", i), 32'(out1), 32'(seq[FrameLen - i]));
      check($sformatf("a5_done%0d", i), 32'(done), 32'(seq_done[FrameLen - i]));
    end

    // Back-to-back 0xFF then 0x00 with In_Valid held high.
    send8(8'hFF);
    send8(8'h00);
    drop8();
    repeat (FrameLen) @(negedge clk);

    // Parity-sensitive word.
    send8(8'h01);
    drop8();
    repeat (FrameLen + 2) @(negedge clk);

    // Randomized traffic with random gaps, including zero-gap back-to-back.
    for (int k = 0; k < 40; k++) begin
      send8(8'($urandom));
      r = $urandom_range(0, 3);
      if (r > 0) begin
        drop8();
        repeat (r - 1) @(negedge clk);
      end
    end
    drop8();
    repeat (FrameLen + 2) @(negedge clk);

    // Reset in the 5th DATA cycle of a 0xF0 frame.
    send8(8'hF0);
    drop8();
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("midreset_out1", 32'(out1), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("postreset_ready", 32'(in_ready), 32'd1);
    send8(8'h3C);
    drop8();
    repeat (FrameLen + 2) @(negedge clk);

    // DATA_W=1 instance: send 1.
    @(negedge clk);
    in_valid1 = 1'b1;
    in_data1  = 1'b1;
    check("w1_ready", 32'(in_ready1), 32'd1);
    @(posedge clk);
    seq1      = ParEn ? 6'b101110 : 6'b010110;
    seq1_done = ParEn ? 6'b000010 : 6'b000010;
    for (int i = 0; i < (ParEn ? 6 : 5); i++) begin
      @(negedge clk);
      if (i == 0) begin
        in_valid1 = 1'b0;
        in_data1  = 1'b0;
      end
      check($sformatf("w1_bit%0d", i), 32'(out1_1), 32'(seq1[(ParEn ? 5 : 4) - i]));
      check($sformatf("w1_done%0d", i), 32'(done1), 32'(seq1_done[(ParEn ? 5 : 4) - i]));
    end
    check("w1_idle_busy", 32'(busy1), 32'd0);

    check("model_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
